// File: rtl/instruction_loader_if.sv
// Loader-side bus: control strobes and UART byte stream in, instruction-memory write port and status out.
interface instruction_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
);
  logic               i_start;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_inst_wr_en;
  logic [NB_ADDR-1:0] o_inst_addr;
  logic [NB_DATA-1:0] o_inst_data;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;

  // Side that drives the loader (UART receiver / control)
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_inst_wr_en, o_inst_addr, o_inst_data, o_busy, o_done, o_overflow, o_word_count
  );

  // The loader itself
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_inst_wr_en, o_inst_addr, o_inst_data, o_busy, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles received bytes (MSB first) into instruction words and writes them to
// consecutive instruction-memory addresses until a HALT word is written.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, waiting for i_start
// RECV    | collecting bytes of the current word
// WRITE   | one-cycle write of the assembled word
// DONE    | HALT word written, waiting for i_start
// ERROR   | memory filled without HALT, waiting for i_start
module instruction_loader #(
  parameter int                   NB_DATA     = 32,
  parameter int                   NB_BYTE     = 8,
  parameter int                   NB_ADDR     = 8,
  parameter int                   NB_OPCODE   = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'h3f
) (
  input  logic i_clock,
  input  logic i_reset,
  instruction_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_ONE = 1;
  localparam logic [NB_ADDR:0]   WC_ONE   = 1;

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [NB_ADDR:0]   wcount_q, wcount_d;
  logic [NB_DATA-1:0] data_q, data_d;

  logic               is_halt;
  logic               addr_last;
  logic [NB_DATA-1:0] data_shift;

  assign is_halt    = (data_q[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE);
  assign addr_last  = &addr_q;
  assign data_shift = {data_q[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};

  // State and datapath registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wcount_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wcount_q <= wcount_d;
      data_q   <= data_d;
    end
  end

  // Next-state and datapath update; i_start always wins over a byte in the same cycle
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wcount_d = wcount_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.i_start) begin
          state_d  = S_RECV;
          addr_d   = '0;
          cnt_d    = '0;
          wcount_d = '0;
        end
      end

      S_RECV: begin
        if (bus.i_start) begin
          addr_d   = '0;
          cnt_d    = '0;
          wcount_d = '0;
        end else if (bus.i_rx_valid) begin
          data_d = data_shift;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (bus.i_start) begin
          // The write of this cycle still happens; only the bookkeeping restarts
          state_d  = S_RECV;
          addr_d   = '0;
          cnt_d    = '0;
          wcount_d = '0;
        end else begin
          addr_d   = addr_q + ADDR_ONE;
          wcount_d = wcount_q + WC_ONE;
          if (is_halt) begin
            state_d = S_DONE;
          end else if (addr_last) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_RECV;
            if (bus.i_rx_valid) begin
              // First byte of the next word arriving back-to-back
              data_d = data_shift;
              cnt_d  = 2'd1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_inst_wr_en = (state_q == S_WRITE);
  assign bus.o_inst_addr  = addr_q;
  assign bus.o_inst_data  = data_q;
  assign bus.o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.o_done       = (state_q == S_DONE);
  assign bus.o_overflow   = (state_q == S_ERROR);
  assign bus.o_word_count = wcount_q;

endmodule
